button_input_conditioner: RTL

- Front-end stage that feeds the lock's next-state logic.
- Converts two raw, asynchronous, bouncing push-buttons ("one" and "zero") into clean single-cycle 2-bit symbol pulses on Input: 2'b10 = one, 2'b01 = zero, 2'b00 = no event.
- Per button: synchronisation, debounce and press-edge detection.
- Arbitration ensures at most one symbol per physical press and rejects overlapping presses.

---
 rtl/button_input_conditioner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/button_input_conditioner.sv
// rtl/button_input_conditioner.sv - two-button sync/debounce/edge front end with press arbitration
// Bit 1 of every per-button vector is the "one" button, bit 0 the "zero" button, matching the symbol encoding.
module button_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Btn_One,
  input  logic       Btn_Zero,
  output logic [1:0] Input,
  output logic       Busy,
  output logic       Conflict
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HELD_ONE,
    S_HELD_ZERO,
    S_WAIT_RELEASE
  } state_t;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [1:0]       r_prev;
  logic [CNT_W-1:0] r_cnt [2];
  state_t           r_state;
  logic [1:0]       r_input;
  logic             r_busy;
  logic             r_conflict;

  logic [1:0]       w_deb_next;
  logic [CNT_W-1:0] w_cnt_next [2];
  logic [1:0]       w_press;
  state_t           w_state_next;
  logic [1:0]       w_sym;
  logic             w_conflict;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_deb_next[i] = r_deb[i];
      w_cnt_next[i] = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == C_LAST) begin
          w_deb_next[i] = ~r_deb[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_press = r_deb & ~r_prev;

  always_comb begin
    w_state_next = r_state;
    w_sym        = 2'b00;
    w_conflict   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A press while the other button is already down is an overlap too.
        if (w_press == 2'b11) begin
          w_conflict   = 1'b1;
          w_state_next = S_WAIT_RELEASE;
        end else if (w_press[1]) begin
          if (r_deb[0]) begin
            w_conflict   = 1'b1;
            w_state_next = S_WAIT_RELEASE;
          end else begin
            w_sym        = 2'b10;
            w_state_next = S_HELD_ONE;
          end
        end else if (w_press[0]) begin
          if (r_deb[1]) begin
            w_conflict   = 1'b1;
            w_state_next = S_WAIT_RELEASE;
          end else begin
            w_sym        = 2'b01;
            w_state_next = S_HELD_ZERO;
          end
        end
      end
      S_HELD_ONE: begin
        if (w_press[0]) begin
          w_conflict   = 1'b1;
          w_state_next = S_WAIT_RELEASE;
        end else if (r_deb == 2'b00) begin
          w_state_next = S_IDLE;
        end
      end
      S_HELD_ZERO: begin
        if (w_press[1]) begin
          w_conflict   = 1'b1;
          w_state_next = S_WAIT_RELEASE;
        end else if (r_deb == 2'b00) begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_RELEASE: begin
        if (r_deb == 2'b00) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync1    <= 2'b00;
      r_sync2    <= 2'b00;
      r_deb      <= 2'b00;
      r_prev     <= 2'b00;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
      r_state    <= S_IDLE;
      r_input    <= 2'b00;
      r_busy     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_sync1    <= {Btn_One, Btn_Zero};
      r_sync2    <= r_sync1;
      r_deb      <= w_deb_next;
      r_prev     <= r_deb;
      r_cnt[0]   <= w_cnt_next[0];
      r_cnt[1]   <= w_cnt_next[1];
      r_state    <= w_state_next;
      r_input    <= w_sym;
      // Busy tracks the debounced level in the same cycle it changes.
      r_busy     <= (w_state_next != S_IDLE) || (|w_deb_next);
      r_conflict <= w_conflict;
    end
  end

  assign Input    = r_input;
  assign Busy     = r_busy;
  assign Conflict = r_conflict;

endmodule
